// File: rtl/puf_auth_sequencer.sv
// Sequences one PUF authentication attempt: challenge, response capture, conversion, compare.
// Tracks consecutive failures with lockout; every wait state is bounded by TIMEOUT_CYCLES.
module puf_auth_sequencer #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd255,
    parameter int          MAX_FAILS      = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] challenge_in,
    input  logic [15:0] expected_n,
    input  logic        clear_lock,
    output logic        puf_req,
    output logic [15:0] puf_challenge,
    input  logic        puf_resp_valid,
    input  logic [15:0] puf_resp_in,
    output logic        convert,
    output logic [15:0] conv_resp,
    input  logic [15:0] n_auth,
    input  logic        conversion_done,
    output logic        busy,
    output logic        auth_done,
    output logic        auth_pass,
    output logic        auth_fail,
    output logic        timeout_err,
    output logic        locked
);

    localparam int FW = ($clog2(MAX_FAILS + 1) > 2) ? $clog2(MAX_FAILS + 1) : 2;
    localparam logic [FW-1:0] FAIL_LIM = FW'(MAX_FAILS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_RESP,
        S_CONV,
        S_WAIT_CONV,
        S_CHECK,
        S_LOCKED
    } state_t;

    state_t         state, state_nxt;
    logic [15:0]    wait_cnt;
    logic [15:0]    expected_q;
    logic [15:0]    n_q;
    logic [FW-1:0]  fail_count;
    logic [FW-1:0]  fail_inc;
    logic           timed_out;
    logic           expire;
    logic           match;

    // Expiring on the last wait cycle makes the timeout land exactly TIMEOUT_CYCLES after entry.
    assign expire   = (wait_cnt == TIMEOUT_CYCLES - 16'd1);
    assign match    = !timed_out && (n_q == expected_q);
    assign fail_inc = (fail_count >= FAIL_LIM) ? fail_count : fail_count + FW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (start) state_nxt = S_REQ;
            S_REQ:       state_nxt = S_WAIT_RESP;
            S_WAIT_RESP: begin
                if (puf_resp_valid) state_nxt = S_CONV;
                else if (expire)    state_nxt = S_CHECK;
            end
            S_CONV:      state_nxt = S_WAIT_CONV;
            S_WAIT_CONV: begin
                if (conversion_done || expire) state_nxt = S_CHECK;
            end
            S_CHECK: begin
                if (!match && (fail_inc == FAIL_LIM)) state_nxt = S_LOCKED;
                else                                  state_nxt = S_IDLE;
            end
            S_LOCKED:    if (clear_lock) state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt      <= 16'd0;
            puf_challenge <= 16'd0;
            expected_q    <= 16'd0;
            conv_resp     <= 16'd0;
            n_q           <= 16'd0;
            fail_count    <= '0;
            timed_out     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        puf_challenge <= challenge_in;
                        expected_q    <= expected_n;
                    end
                end
                S_REQ: begin
                    wait_cnt  <= 16'd0;
                    timed_out <= 1'b0;
                end
                S_WAIT_RESP: begin
                    if (puf_resp_valid) begin
                        conv_resp <= puf_resp_in;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                        if (expire) timed_out <= 1'b1;
                    end
                end
                S_CONV: wait_cnt <= 16'd0;
                S_WAIT_CONV: begin
                    if (conversion_done) begin
                        n_q <= n_auth;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                        if (expire) timed_out <= 1'b1;
                    end
                end
                S_CHECK: begin
                    if (match) fail_count <= '0;
                    else       fail_count <= fail_inc;
                end
                S_LOCKED: if (clear_lock) fail_count <= '0;
                default: ;
            endcase
        end
    end

    // Status outputs decode straight from the state register, so reset clears them at once.
    assign puf_req     = (state == S_REQ);
    assign convert     = (state == S_CONV);
    assign busy        = (state != S_IDLE) && (state != S_LOCKED);
    assign auth_done   = (state == S_CHECK);
    assign auth_pass   = (state == S_CHECK) && match;
    assign auth_fail   = (state == S_CHECK) && !match;
    assign timeout_err = (state == S_CHECK) && timed_out;
    assign locked      = (state == S_LOCKED);

endmodule

// File: tb/tb_puf_auth_sequencer.sv
// Bench for puf_auth_sequencer: directed scenarios plus randomized attempts scored
// against a timeline model of each attempt and a failure-count lockout model.
module tb_puf_auth_sequencer;

    localparam logic [15:0] T  = 16'd24;
    localparam int          TI = 24;
    localparam int          MF = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] challenge_in;
    logic [15:0] expected_n;
    logic        clear_lock;
    logic        puf_req;
    logic [15:0] puf_challenge;
    logic        puf_resp_valid;
    logic [15:0] puf_resp_in;
    logic        convert;
    logic [15:0] conv_resp;
    logic [15:0] n_auth;
    logic        conversion_done;
    logic        busy;
    logic        auth_done;
    logic        auth_pass;
    logic        auth_fail;
    logic        timeout_err;
    logic        locked;

    int checks   = 0;
    int failures = 0;
    int model_fails = 0;

    puf_auth_sequencer #(.TIMEOUT_CYCLES(T), .MAX_FAILS(MF)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .challenge_in(challenge_in),
        .expected_n(expected_n), .clear_lock(clear_lock), .puf_req(puf_req),
        .puf_challenge(puf_challenge), .puf_resp_valid(puf_resp_valid),
        .puf_resp_in(puf_resp_in), .convert(convert), .conv_resp(conv_resp),
        .n_auth(n_auth), .conversion_done(conversion_done), .busy(busy),
        .auth_done(auth_done), .auth_pass(auth_pass), .auth_fail(auth_fail),
        .timeout_err(timeout_err), .locked(locked)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_outs"}, {puf_req, convert, busy, auth_done, auth_pass, auth_fail,
                             timeout_err, locked}, 32'd0);
        chk({tag, "_data"}, {puf_challenge, conv_resp}, 32'd0);
    endtask

    // One attempt. rd/cd: cycles spent in each wait state before the strobe; >= T means never.
    task automatic attempt(input string tag, input logic [15:0] ch, input logic [15:0] ex,
                           input logic [15:0] rsp, input logic [15:0] nv,
                           input int rd, input int cd, input bit hold, input bit stray);
        int  cyc, exp_done, exp_conv, done_cyc, req_cnt, req_cyc, conv_cnt, conv_cyc;
        bit  to, pass, got, lk;
        logic [15:0] conv_val, conv_at_done, chal_at_done;
        logic [2:0]  flags;
        to       = (rd >= TI) || (rd < TI && cd >= TI);
        exp_conv = (rd >= TI) ? -1 : 3 + rd;
        exp_done = (rd >= TI) ? 2 + TI : ((cd >= TI) ? 4 + rd + TI : 5 + rd + cd);
        pass     = !to && (nv == ex);
        if (pass) model_fails = 0;
        else if (model_fails < MF) model_fails++;
        lk = (model_fails == MF);

        start = 1'b1; challenge_in = ch; expected_n = ex; puf_resp_in = rsp; n_auth = nv;
        cyc = 0; got = 0; done_cyc = -1; req_cnt = 0; req_cyc = -1; conv_cnt = 0; conv_cyc = -1;
        conv_val = 16'd0; conv_at_done = 16'd0; chal_at_done = 16'd0; flags = 3'd0;
        while (!got && cyc < exp_done + 8) begin
            tick();
            cyc++;
            if (!hold) start = 1'b0;
            challenge_in = 16'($urandom);
            expected_n   = 16'($urandom);
            if (puf_req) begin req_cnt++; req_cyc = cyc; end
            if (convert) begin conv_cnt++; conv_cyc = cyc; conv_val = conv_resp; end
            if (auth_done) begin
                got = 1; done_cyc = cyc;
                flags = {auth_pass, auth_fail, timeout_err};
                conv_at_done = conv_resp; chal_at_done = puf_challenge;
            end
            puf_resp_valid  = (rd < TI && cyc == 2 + rd) || (stray && cyc == exp_conv);
            puf_resp_in     = (cyc == exp_conv) ? ~rsp : rsp;
            conversion_done = (exp_conv >= 0 && cd < TI && cyc == exp_conv + 1 + cd) ||
                              (stray && cyc == 1);
            n_auth          = (cyc == 1) ? ~nv : nv;
        end
        chk({tag, "_done_cycle"}, done_cyc, exp_done);
        chk({tag, "_flags"}, {29'd0, flags}, {29'd0, pass, !pass, to});
        chk({tag, "_req"}, {req_cnt[15:0], req_cyc[15:0]}, {16'd1, 16'd1});
        chk({tag, "_chal"}, {16'd0, chal_at_done}, {16'd0, ch});
        if (rd < TI) begin
            chk({tag, "_conv"}, {conv_cnt[15:0], conv_cyc[15:0]}, {16'd1, 16'(exp_conv)});
            chk({tag, "_conv_resp"}, {conv_val, conv_at_done}, {rsp, rsp});
        end else begin
            chk({tag, "_no_conv"}, conv_cnt, 0);
        end
        tick();
        puf_resp_valid = 1'b0;
        conversion_done = 1'b0;
        chk({tag, "_after"}, {29'd0, locked, busy, auth_done}, {29'd0, lk, 1'b0, 1'b0});
    endtask

    task automatic unlock();
        clear_lock = 1'b1;
        tick();
        clear_lock = 1'b0;
        model_fails = 0;
        chk("unlock", {30'd0, locked, busy}, 32'd0);
    endtask

    initial begin
        bit seen;
        int rd, cd;
        logic [15:0] ex, nv;
        rst_n = 1'b0; start = 1'b0; challenge_in = 16'd0; expected_n = 16'd0;
        clear_lock = 1'b0; puf_resp_valid = 1'b0; puf_resp_in = 16'd0;
        n_auth = 16'd0; conversion_done = 1'b0;
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        attempt("basic", 16'hA5A5, 16'h1234, 16'h1234, 16'h1234, 0, 0, 0, 0);
        attempt("stray", 16'h3C3C, 16'h0042, 16'h7777, 16'h0042, 2, 3, 0, 1);

        attempt("lk1", 16'h1111, 16'h1234, 16'h1234, 16'h1235, 0, 0, 0, 0);
        attempt("lk2", 16'h2222, 16'h1234, 16'h1234, 16'h1235, 1, 0, 0, 0);
        attempt("lk3", 16'h3333, 16'h1234, 16'h1234, 16'h1235, 0, 2, 0, 0);
        start = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (puf_req || busy || !locked) seen = 1;
        end
        start = 1'b0;
        chk("locked_ignores_start", {31'd0, seen}, 32'd0);
        unlock();
        attempt("post_unlock", 16'h4444, 16'h1234, 16'h1234, 16'h1234, 0, 0, 0, 0);

        attempt("mix_f1", 16'h5555, 16'h00FF, 16'h1, 16'h00FE, 0, 1, 0, 0);
        attempt("mix_f2", 16'h6666, 16'h00FF, 16'h2, 16'h00FE, 1, 1, 0, 0);
        attempt("mix_p",  16'h7777, 16'h00FF, 16'h3, 16'h00FF, 0, 0, 0, 0);
        attempt("mix_f3", 16'h8888, 16'h00FF, 16'h4, 16'h0000, 0, 0, 0, 0);

        attempt("to_resp", 16'h9999, 16'hBEEF, 16'h5, 16'hBEEF, TI, 0, 0, 0);
        attempt("to_conv", 16'hAAAA, 16'hBEEF, 16'h6, 16'hBEEF, 1, TI, 0, 0);
        unlock();
        attempt("edge_prio", 16'hBBBB, 16'hCAFE, 16'h7, 16'hCAFE, TI - 1, TI - 1, 0, 0);

        attempt("hold1", 16'hC001, 16'h0001, 16'h8, 16'h0001, 0, 0, 1, 0);
        attempt("hold2", 16'hC002, 16'h0002, 16'h9, 16'h0002, 1, 2, 1, 0);
        attempt("hold3", 16'hC003, 16'h0003, 16'hA, 16'h0003, 0, 0, 0, 0);

        // Reset while waiting on the converter.
        start = 1'b1; challenge_in = 16'h0F0F; expected_n = 16'h0F0F;
        tick();
        start = 1'b0;
        tick();
        puf_resp_valid = 1'b1; puf_resp_in = 16'hD00D;
        tick();
        puf_resp_valid = 1'b0;
        tick();
        chk("rst_mid_busy", {31'd0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        conversion_done = 1'b1; n_auth = 16'h0F0F;
        @(negedge clk);
        rst_n = 1'b1;
        model_fails = 0;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (busy || auth_done || puf_req) seen = 1;
        end
        conversion_done = 1'b0;
        chk("rst_late_done_ignored", {31'd0, seen}, 32'd0);
        attempt("after_rst", 16'h1357, 16'h2468, 16'h2468, 16'h2468, 0, 0, 0, 0);

        for (int k = 0; k < 16; k++) begin
            rd = ($urandom_range(0, 5) == 0) ? TI : int'($urandom_range(0, 5));
            cd = ($urandom_range(0, 5) == 0) ? TI : int'($urandom_range(0, 5));
            ex = 16'($urandom);
            nv = $urandom_range(0, 1) ? ex : ex ^ (16'd1 << $urandom_range(0, 15));
            attempt($sformatf("rnd%0d", k), 16'($urandom), ex, 16'($urandom), nv,
                    rd, cd, 0, bit'($urandom_range(0, 1)));
            if (model_fails == MF) unlock();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
